if_fetch_stage: RTL
===================

IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 SHALL have ports `clk` (in, 1, sole clock) and `reset` (in, 1). `reset` is synchronous and active-low.
REQ-002 SHALL have `stall` (in, 1): hazard-unit hold request; freezes the PC and any held instruction.
REQ-003 SHALL have `branch_taken` (in, 1) and `branch_target` (in, 32): resolved branch redirect.
REQ-004 SHALL have `jump` (in, 1) and `jump_target` (in, 32): J/JAL redirect.
REQ-005 SHALL have `jr` (in, 1) and `jr_target` (in, 32): JR/JALR redirect.
REQ-006 SHALL have `illop`, `xadr` and `interrupt` (in, 1 each): exception and interrupt requests.
REQ-007 SHALL have `imem_req` (out, 1), `imem_addr` (out, 32), `imem_rdata` (in, 32) and `imem_ready` (in, 1): instruction-memory handshake.
REQ-008 SHALL have `IFInstruction` (out, 32), `IFPC` (out, 32) and `if_valid` (out, 1): payload to the IF/ID register.
  - `IFPC` is the address of `IFInstruction`.
  - When `if_valid`=0, the IF/ID register loads a bubble.
REQ-009 SHALL have `fetch_xadr` (out, 1): misaligned fetch address detected.

Function
REQ-010 SHALL implement FSM states FETCH (`imem_req`=1, waiting for `imem_ready`) and HOLD (instruction captured, waiting for `stall`=0).
REQ-011 In FETCH, `imem_ready`=1 and `stall`=0:
  - present `imem_rdata`/PC on `IFInstruction`/`IFPC` with `if_valid`=1 in the same cycle;
  - load the next PC;
  - stay in FETCH.
REQ-012 In FETCH, `imem_ready`=1 and `stall`=1: capture `imem_rdata` into the hold register and go to HOLD.
REQ-013 In FETCH with `imem_ready`=0: `if_valid`=0 and PC unchanged.
REQ-014 In HOLD: `imem_req`=0 and outputs driven from the hold register.
  - `if_valid`=1 only when `stall`=0.
  - On `stall`=0, advance the PC and return to FETCH.
REQ-015 Next-PC priority, highest first:
  1. `illop` or `xadr` -> 0x80000008;
  2. `interrupt` with PC[31]=0 -> 0x80000004;
  3. `jr` -> `jr_target`;
  4. `jump` -> `jump_target`;
  5. `branch_taken` -> `branch_target`;
  6. otherwise PC+4, mod 2^32 (wraps).
REQ-016 Any redirect (priority items 1-5) SHALL override `stall`, in any state:
  - load the new PC;
  - discard any held or in-flight instruction;
  - force `if_valid`=0 that cycle;
  - go to FETCH.
REQ-017 `interrupt` while PC[31]=1 SHALL be ignored (kernel mode).
REQ-018 `imem_addr` SHALL equal the current PC combinationally.

Reset
REQ-019 On `reset`=0 at a clock edge, state SHALL become:
  - PC=0x80000000, FSM=FETCH;
  - hold register=0, `fetch_xadr`=0.
REQ-020 While `reset`=0, `if_valid` SHALL be 0. The first fetch SHALL target 0x80000000 in the first cycle after reset deasserts.
REQ-021 Reset SHALL override all redirects and handshakes, including mid-transaction.

Configuration
REQ-022 Macro `IF_ALIGN_CHECK_EN` defined:
  - PC[1:0]≠0 drives `fetch_xadr`=1, `imem_req`=0 and `if_valid`=0;
  - the PC holds until a redirect arrives.
REQ-023 Macro `IF_ALIGN_CHECK_EN` undefined:
  - `imem_addr`[1:0] is forced to 0;
  - `fetch_xadr` is tied to 0.

Structure
REQ-024 The shared package `cpu_pkg` SHALL hold:
  - RESET_VEC=0x80000000, INTR_VEC=0x80000004, EXCP_VEC=0x80000008;
  - the IF FSM state enum.
REQ-025 Next-PC priority logic SHALL be the combinational sub-module `pc_next_sel`. The PC register, FSM and hold register stay in `if_fetch_stage`.

Verification
REQ-026 Release reset, hold `imem_ready`=1 -> `IFPC` sequence 0x80000000, 0x80000004, 0x80000008 with `if_valid`=1 each cycle.
REQ-027 Raise `stall` for 3 cycles while `imem_ready`=1 at PC 0x80000010 -> FSM enters HOLD; `IFInstruction` stable; `if_valid`=0. After release, 0x80000010 is issued once and the next PC is 0x80000014.
REQ-028 Assert `jr`=1 (0x00400000) and `branch_taken`=1 (0x00000100) together while `stall`=1 -> PC=0x00400000 next cycle; `if_valid`=0 during the redirect cycle.
REQ-029 PC=0x00400020, raise `interrupt` -> PC=0x80000004. Repeat with PC=0x80000020 -> interrupt ignored; PC=0x80000024.
REQ-030 With `IF_ALIGN_CHECK_EN` defined, `jump_target`=0x00400002 -> `fetch_xadr`=1, `imem_req`=0. A subsequent `xadr`=1 -> PC=0x80000008.
REQ-031 Hold `imem_ready`=0 for 4 cycles, then pulse `reset`=0 -> PC=0x80000000, FSM=FETCH, `if_valid`=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: architectural vectors and the IF stage FSM states.
// Fetch alignment checking is enabled by defining IF_ALIGN_CHECK_EN.
package cpu_pkg;

    localparam logic [31:0] RESET_VEC = 32'h8000_0000;
    localparam logic [31:0] INTR_VEC  = 32'h8000_0004;
    localparam logic [31:0] EXCP_VEC  = 32'h8000_0008;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_HOLD  = 1'b1
    } if_state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority selection for the fetch stage.
// Purely combinational; redirect flags any non-sequential next PC.
module pc_next_sel
    import cpu_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        illop,
    input  logic        xadr,
    input  logic        interrupt,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic [31:0] next_pc,
    output logic        redirect
);

    always_comb begin
        redirect = 1'b1;
        next_pc  = pc + 32'd4;
        if (illop || xadr) begin
            next_pc = EXCP_VEC;
        end else if (interrupt && !pc[31]) begin
            // Kernel-mode PCs (bit 31 set) are not interruptible
            next_pc = INTR_VEC;
        end else if (jr) begin
            next_pc = jr_target;
        end else if (jump) begin
            next_pc = jump_target;
        end else if (branch_taken) begin
            next_pc = branch_target;
        end else begin
            redirect = 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, fetch/hold FSM and hold register.
// Define IF_ALIGN_CHECK_EN to flag misaligned fetch addresses via fetch_xadr.
module if_fetch_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        jr,
    input  logic [31:0] jr_target,
    input  logic        illop,
    input  logic        xadr,
    input  logic        interrupt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] IFInstruction,
    output logic [31:0] IFPC,
    output logic        if_valid,
    output logic        fetch_xadr
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] hold_q, hold_d;
    logic [31:0] next_pc;
    logic        redirect;
    logic        misaligned;

    pc_next_sel u_pc_next_sel (
        .pc            (pc_q),
        .illop         (illop),
        .xadr          (xadr),
        .interrupt     (interrupt),
        .jr            (jr),
        .jr_target     (jr_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .next_pc       (next_pc),
        .redirect      (redirect)
    );

`ifdef IF_ALIGN_CHECK_EN
    assign misaligned = |pc_q[1:0];
    assign fetch_xadr = misaligned;
    assign imem_addr  = pc_q;
`else
    assign misaligned = 1'b0;
    assign fetch_xadr = 1'b0;
    assign imem_addr  = {pc_q[31:2], 2'b00};
`endif

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        hold_d        = hold_q;
        imem_req      = 1'b0;
        if_valid      = 1'b0;
        IFInstruction = imem_rdata;
        IFPC          = pc_q;
        unique case (state_q)
            S_FETCH: begin
                imem_req = !misaligned;
                if (!misaligned && imem_ready) begin
                    if (stall) begin
                        hold_d  = imem_rdata;
                        state_d = S_HOLD;
                    end else begin
                        if_valid = 1'b1;
                        pc_d     = next_pc;
                    end
                end
            end
            S_HOLD: begin
                IFInstruction = hold_q;
                if (!stall) begin
                    if_valid = 1'b1;
                    pc_d     = next_pc;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
        // A redirect wins over stall and squashes whatever is in flight
        if (redirect) begin
            pc_d     = next_pc;
            state_d  = S_FETCH;
            if_valid = 1'b0;
        end
        if (!reset) begin
            if_valid = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q    <= RESET_VEC;
            state_q <= S_FETCH;
            hold_q  <= '0;
        end else begin
            pc_q    <= pc_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

endmodule
